// File: rtl/digit_stabilizer_if.sv
// Recognised-digit sample bus into the stabiliser and the published digit
// coming back out of it toward the board display and UART reporting.
interface digit_stabilizer_if;
    logic       frame_vsync;
    logic [3:0] digit;
    logic [3:0] stable_digit;
    logic       stable_valid;
    logic       update_pulse;
    logic [6:0] seg_n;

    modport master (
        output frame_vsync, digit,
        input  stable_digit, stable_valid, update_pulse, seg_n
    );

    modport slave (
        input  frame_vsync, digit,
        output stable_digit, stable_valid, update_pulse, seg_n
    );
endinterface

// File: rtl/digit_stabilizer.sv
// Per-frame digit debouncer: publishes a digit after CONFIRM_FRAMES matching
// frames and withdraws it after LOST_FRAMES disagreeing frames.
module digit_stabilizer #(
    parameter int CONFIRM_FRAMES = 4,
    parameter int LOST_FRAMES    = 8,
    parameter int CNT_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    digit_stabilizer_if.slave bus
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM_FRAMES);
    localparam logic [CNT_W-1:0] LOST_C    = CNT_W'(LOST_FRAMES);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [3:0]       NONE_C    = 4'hF;
    localparam logic [6:0]       DASH_C    = 7'b0111111;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + ONE_C;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return DASH_C;
        endcase
    endfunction

    state_t           state;
    logic             vs_d1;
    logic [3:0]       cand;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [3:0]       stable_digit_r;
    logic             stable_valid_r;
    logic             update_pulse_r;
    logic [6:0]       seg_n_r;

    logic             sample_evt;
    logic             sample_ok;
    logic             confirm;
    logic [CNT_W-1:0] match_nxt;
    logic [CNT_W-1:0] miss_nxt;

    // Sample decode: one event per vsync rising edge
    always_comb begin
        sample_evt = bus.frame_vsync & ~vs_d1;
        sample_ok  = (bus.digit <= 4'd9);
        match_nxt  = (bus.digit == cand) ? sat_inc(match_cnt) : ONE_C;
        miss_nxt   = sat_inc(miss_cnt);
        confirm    = sample_ok && (match_nxt >= CONFIRM_C);
    end

    // Registered tracking and publish stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SEARCH;
            vs_d1          <= 1'b1;
            cand           <= NONE_C;
            match_cnt      <= '0;
            miss_cnt       <= '0;
            stable_digit_r <= NONE_C;
            stable_valid_r <= 1'b0;
            update_pulse_r <= 1'b0;
            seg_n_r        <= DASH_C;
        end else begin
            vs_d1          <= bus.frame_vsync;
            update_pulse_r <= 1'b0;
            if (sample_evt) begin
                cand      <= bus.digit;
                match_cnt <= match_nxt;
                case (state)
                    SEARCH: begin
                        if (confirm) begin
                            stable_digit_r <= bus.digit;
                            stable_valid_r <= 1'b1;
                            seg_n_r        <= seg_decode(bus.digit);
                            miss_cnt       <= '0;
                            update_pulse_r <= 1'b1;
                            state          <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        // Confirm is checked before lost so a new digit switches directly
                        if (bus.digit == stable_digit_r) begin
                            miss_cnt <= '0;
                        end else if (confirm) begin
                            stable_digit_r <= bus.digit;
                            seg_n_r        <= seg_decode(bus.digit);
                            miss_cnt       <= '0;
                            update_pulse_r <= 1'b1;
                        end else if (miss_nxt >= LOST_C) begin
                            stable_digit_r <= NONE_C;
                            stable_valid_r <= 1'b0;
                            seg_n_r        <= DASH_C;
                            miss_cnt       <= '0;
                            update_pulse_r <= 1'b1;
                            state          <= SEARCH;
                        end else begin
                            miss_cnt <= miss_nxt;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.stable_digit = stable_digit_r;
    assign bus.stable_valid = stable_valid_r;
    assign bus.update_pulse = update_pulse_r;
    assign bus.seg_n        = seg_n_r;

endmodule

// File: doc/digit_stabilizer.md
Name: digit_stabilizer

Overview:
- Downstream of the vision pipeline's digit recognition output.
- Samples the per-frame recognised digit once per frame and suppresses single-frame misreads. It publishes a digit only after it has been seen in CONFIRM_FRAMES consecutive frames.
- Drops the published digit after LOST_FRAMES consecutive frames disagree with it.
- Drives a registered active-low 7-segment code and a one-cycle change pulse for the board display and UART reporting logic.

Parameters:
CONFIRM_FRAMES  4  consecutive identical valid samples needed to publish a digit; legal range 1..2^CNT_W-1
LOST_FRAMES     8  consecutive samples differing from the published digit before it is withdrawn; legal range 1..2^CNT_W-1
CNT_W           4  width of match and miss counters; both counters saturate at 2^CNT_W-1

Ports:
clk            input   1  pixel clock, same domain as the recognition pipeline
rst            input   1  synchronous, active-high reset
frame_vsync    input   1  frame vertical sync from the binarization stage; the rising edge marks end-of-frame
digit          input   4  recognised digit; 0..9 are valid, any value 10..15 means "no digit"
stable_digit   output  4  published digit; 4'hF when nothing is published
stable_valid   output  1  high while stable_digit holds a published 0..9
update_pulse   output  1  one-cycle pulse whenever stable_digit/stable_valid change
seg_n          output  7  active-low segments {g,f,e,d,c,b,a} of stable_digit

Behaviour:
- Clocking and reset: clk only. rst is synchronous and active-high.
- Reset values:
  - stable_digit=4'hF, stable_valid=0, update_pulse=0, seg_n=7'b0111111 (dash).
  - cand=4'hF, match_cnt=0, miss_cnt=0, state=SEARCH.
  - vs_d1=1, so a frame_vsync already high at reset release is not a sample event.
  - Reset asserted mid-frame or mid-confirm discards all history.
- Sample event: the cycle where frame_vsync=1 and vs_d1=0. The digit input value in that cycle is the sample.
- Latency: all outputs are registered and change in the cycle after the sample event (1-cycle latency). No activity occurs outside sample events.
- Candidate tracking, on every sample:
  - If the sample equals cand: match_cnt = match_cnt+1, saturating.
  - Otherwise: cand=sample, match_cnt=1.
  - Invalid samples (>9) are tracked the same way but can never confirm.
- Confirm condition: the sample is valid (0..9) and the updated match_cnt is >= CONFIRM_FRAMES.
- State SEARCH:
  - On the confirm condition: stable_digit=sample, stable_valid=1, miss_cnt=0, update_pulse=1, go to LOCKED.
  - Otherwise: stay in SEARCH.
- State LOCKED:
  - Sample equals stable_digit: miss_cnt=0, no pulse.
  - Sample differs (another valid digit or invalid): miss_cnt = miss_cnt+1, saturating.
  - Confirm condition met with sample != stable_digit: stable_digit=sample, miss_cnt=0, update_pulse=1, stay in LOCKED (direct switch).
  - Otherwise, if the updated miss_cnt >= LOST_FRAMES: stable_digit=4'hF, stable_valid=0, miss_cnt=0, update_pulse=1, go to SEARCH.
  - Simultaneous confirm and lost on the same sample: confirm wins.
- update_pulse is high for exactly one clk cycle. It is never asserted when the published value does not change.
- seg_n is decoded from the next-state stable_digit and registered with it, so it is always consistent with stable_digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - all other values = 0111111
- frame_vsync held high for many cycles produces one sample. frame_vsync glitch-free operation is required from upstream; no debounce is performed.

Test Plan:
- After reset, send 4 frames with digit=7 → update_pulse for one cycle after the 4th vsync rise; stable_digit=7, stable_valid=1, seg_n=1111000. Frames 1-3 leave the outputs at reset values.
- Locked on 7, send the sequence 7,3,7,7 → no pulse, stable_digit stays 7, miss_cnt returns to 0.
- Locked on 7, send 4 frames of digit=2 → single pulse after the 4th; stable_digit=2, stable_valid stays 1, no intermediate 4'hF.
- Locked on 7, send 8 frames of digit=4'hF → pulse after the 8th; stable_digit=4'hF, stable_valid=0, seg_n=0111111, state SEARCH.
- CONFIRM_FRAMES=1, LOST_FRAMES=1, locked on 5, send digit=6 → one pulse, stable_digit=6 (confirm beats lost).
- Assert rst for 1 cycle during the 3rd of 4 confirming frames, with frame_vsync held high across release → outputs at reset values, no sample on release; confirmation restarts and needs 4 fresh frames.
